fft_sink: RTL and testbench
===========================

Name: fft_sink

Overview:
- AXI-Stream slave that captures one 512-point complex FFT output frame (64-bit beats) into an internal RAM.
- Computes |X[k]|² per bin on the fly and tracks the peak bin inside a configurable band, giving a heart-rate bin estimate for the PPG path.
- Counterpart of datasrc: datasrc feeds the FFT core; fft_sink drains it.
- Stored frame can be read back afterwards through a simple synchronous read port.

Parameters:
- N_LOG2, 9, log2 of frame length (512 beats per frame).
- BIN_MIN, 1, lowest bin considered for the peak (excludes DC).
- BIN_MAX, 255, highest bin considered for the peak (excludes the mirrored upper half).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; arms capture of the next frame.
- tdata  in  64  beat payload: re = tdata[31:0] signed, im = tdata[63:32] signed.
- tvalid  in  1  beat valid.
- tlast  in  1  end-of-frame marker.
- tready  out  1  sink ready.
- busy  out  1  high from start until frame_done.
- frame_done  out  1  one-cycle pulse when the frame and peak result are complete.
- peak_bin  out  9  index of the maximum-magnitude bin.
- peak_mag  out  64  unsigned re²+im² of peak_bin.
- tlast_err  out  1  sticky framing error for the current frame.
- rd_addr  in  9  readback address.
- rd_data  out  64  readback data, 1-cycle latency.

Behaviour:
- Reset values: tready=0, busy=0, frame_done=0, peak_bin=0, peak_mag=0, tlast_err=0, rd_data=0, state=IDLE. RAM contents are not reset.
- States:
  - IDLE: tready=0. On start, clear the beat counter, clear the running max, clear tlast_err, set busy=1, go to RECV.
  - RECV: tready=1. A beat is accepted when tvalid && tready. An accepted beat writes RAM[cnt] and cnt increments. On acceptance of beat 511, tready drops the next cycle and the state goes to DRAIN.
  - DRAIN: waits 2 cycles for the magnitude/compare pipeline. Then, in a single cycle: pulse frame_done, set busy=0, update peak_bin/peak_mag, and return to IDLE.
- start outside IDLE is ignored.
- tvalid gaps: no counter advance and no write while tvalid=0.
- Magnitude pipeline:
  - Stage 1 registers re² and im² (signed 32x32 → 64).
  - Stage 2 forms the 64-bit unsigned sum (max 2^63, no overflow) and compares it against the running max.
- Peak update:
  - Only bins with BIN_MIN ≤ k ≤ BIN_MAX are compared.
  - Update only on strictly greater, so on ties the lowest index wins.
  - If every in-band bin is 0, the result is peak_bin=BIN_MIN, peak_mag=0.
- peak_bin and peak_mag hold their last results until the next frame_done; they are not disturbed during capture.
- tlast checking:
  - tlast on any accepted beat other than 511 → tlast_err=1.
  - tlast low on beat 511 → tlast_err=1.
  - The frame always completes at 512 beats; there is no resync on tlast.
  - tlast_err holds until the next accepted start or reset.
- Readback:
  - rd_data = RAM[rd_addr] registered; valid in any state.
  - Read and write to the same address in the same cycle returns the old data.
- Reset mid-frame: the state returns to IDLE within one cycle, outputs take their reset values, and partial RAM contents are left as-is.

Optional Feature:
- Macro: FFT_SINK_STALL_EN.
- Defined: adds input port stall (1 bit). In RECV, tready = ~stall. This allows bench and system back-pressure injection; beats are accepted only while stall=0.
- Undefined: no stall port; tready is constant 1 throughout RECV.

Decomposition:
- Package fft_pkg holds:
  - FFT_N_LOG2=9 and FFT_N=512.
  - DATA_W=64 and HALF_W=32.
  - The state enum {IDLE, RECV, DRAIN}.
  - Default BIN_MIN/BIN_MAX values, shared with datasrc.
- One sub-module: cplx_mag2, the 2-stage re²+im² pipeline (in: 64-bit sample plus valid plus bin index; out: 64-bit magnitude plus valid plus index).
- The RAM is inferred inline.

Test Plan:
- Nominal peak: start, then 512 beats with continuous tvalid. Bin 37 = {im=0, re=1000}, all other bins = {1,1}, tlast on beat 511. Required: frame_done 3 cycles after the last handshake, peak_bin=37, peak_mag=1000000, tlast_err=0.
- Bursty source: same data with tvalid toggling 8 on / 4 off. Required: identical result, exactly 512 RAM writes, rd_addr=37 → rd_data=0x00000000_000003E8 next cycle.
- Band limits and ties:
  - Largest values placed at bin 0 and bin 300. Required: both ignored, peak is the largest in-band bin.
  - Equal maxima at bins 20 and 40. Required: peak_bin=20.
- Framing error:
  - tlast asserted on beat 100 and low on beat 511. Required: tlast_err=1 from beat 100, frame still ends at 512.
  - Next start followed by a clean frame. Required: tlast_err=0.
- Reset and start during capture:
  - Reset asserted after 200 beats. Required: tready=0, busy=0, peak outputs 0 next cycle.
  - start pulsed during RECV. Required: ignored.
- FFT_SINK_STALL_EN: stall pattern 10 cycles high, 4 low, 5 high, matching the datasrc bench's tready pattern. Required: no beat accepted while stall=1, results identical to the nominal case.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT constants, sample widths, sink FSM encoding and default peak-search band
// (the band defaults are shared with datasrc).
package fft_pkg;

  localparam int FFT_N_LOG2 = 9;
  localparam int FFT_N      = 1 << FFT_N_LOG2;
  localparam int DATA_W     = 64;
  localparam int HALF_W     = DATA_W / 2;

  localparam int BIN_MIN_DEF = 1;
  localparam int BIN_MAX_DEF = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/cplx_mag2.sv
// Two-stage |x|^2 pipeline: signed re^2 and im^2 products, then their unsigned sum.
// The bin index and valid travel with the sample.
module cplx_mag2 #(
  parameter int DATA_W = fft_pkg::DATA_W,
  parameter int IDX_W  = fft_pkg::FFT_N_LOG2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_p0,
  input  logic              vld_p0,
  input  logic [IDX_W-1:0]  idx_p0,
  output logic [DATA_W-1:0] mag_p2,
  output logic              vld_p2,
  output logic [IDX_W-1:0]  idx_p2
);

  localparam int HALF = DATA_W / 2;

  logic signed [HALF-1:0]   re_p0;
  logic signed [HALF-1:0]   im_p0;
  logic signed [DATA_W-1:0] re_sq_p1;
  logic signed [DATA_W-1:0] im_sq_p1;
  logic                     vld_p1;
  logic [IDX_W-1:0]         idx_p1;

  function automatic logic signed [DATA_W-1:0] square(input logic signed [HALF-1:0] x);
    logic signed [DATA_W-1:0] xe;
    xe = {{HALF{x[HALF-1]}}, x};
    return xe * xe;
  endfunction

  // Both squares are non-negative and at most 2^62, so the sum fits in DATA_W bits unsigned.
  function automatic logic [DATA_W-1:0] mag_sum(input logic signed [DATA_W-1:0] a,
                                                input logic signed [DATA_W-1:0] b);
    return $unsigned(a) + $unsigned(b);
  endfunction

  assign re_p0 = data_p0[HALF-1:0];
  assign im_p0 = data_p0[DATA_W-1:HALF];

  // p0 -> p1: squares
  always_ff @(posedge clk) begin
    re_sq_p1 <= square(re_p0);
    im_sq_p1 <= square(im_p0);
    idx_p1   <= idx_p0;
  end

  always_ff @(posedge clk) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= vld_p0;
  end

  // p1 -> p2: magnitude sum
  always_ff @(posedge clk) begin
    mag_p2 <= mag_sum(re_sq_p1, im_sq_p1);
    idx_p2 <= idx_p1;
  end

  always_ff @(posedge clk) begin
    if (reset) vld_p2 <= 1'b0;
    else       vld_p2 <= vld_p1;
  end

endmodule

// File: rtl/fft_sink.sv
// AXI-Stream sink for one FFT frame: stores beats in RAM, tracks the in-band peak |X[k]|^2.
// Define FFT_SINK_STALL_EN to add a stall input that gates tready while receiving.
module fft_sink
  import fft_pkg::*;
#(
  parameter int N_LOG2  = FFT_N_LOG2,
  parameter int BIN_MIN = BIN_MIN_DEF,
  parameter int BIN_MAX = BIN_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] tdata,
  input  logic              tvalid,
  input  logic              tlast,
`ifdef FFT_SINK_STALL_EN
  input  logic              stall,
`endif
  output logic              tready,
  output logic              busy,
  output logic              frame_done,
  output logic [N_LOG2-1:0] peak_bin,
  output logic [DATA_W-1:0] peak_mag,
  output logic              tlast_err,
  input  logic [N_LOG2-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int N = 1 << N_LOG2;

  state_t              state;
  logic [N_LOG2-1:0]   cnt;
  logic [1:0]          drain_cnt;
  logic                accept;
  logic                last_beat;

  logic [DATA_W-1:0]   ram [N];

  logic [DATA_W-1:0]   mag_p2;
  logic                vld_p2;
  logic [N_LOG2-1:0]   idx_p2;
  logic [DATA_W-1:0]   run_mag;
  logic [N_LOG2-1:0]   run_bin;

  function automatic logic in_band(input logic [N_LOG2-1:0] k);
    return (int'(k) >= BIN_MIN) && (int'(k) <= BIN_MAX);
  endfunction

  always_comb begin
    tready = 1'b0;
    if (state == RECV) begin
`ifdef FFT_SINK_STALL_EN
      tready = ~stall;
`else
      tready = 1'b1;
`endif
    end
  end

  assign accept    = tvalid && tready;
  assign last_beat = &cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      drain_cnt  <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      tlast_err  <= 1'b0;
      peak_bin   <= '0;
      peak_mag   <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt       <= '0;
            tlast_err <= 1'b0;
            busy      <= 1'b1;
            state     <= RECV;
          end
        end
        RECV: begin
          if (accept) begin
            cnt <= cnt + 1'b1;
            // tlast must be high on the final beat and only there
            if (tlast != last_beat) tlast_err <= 1'b1;
            if (last_beat) begin
              drain_cnt <= '0;
              state     <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Two cycles let the final beat clear the magnitude/compare pipeline
          if (drain_cnt == 2'd2) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            peak_bin   <= run_bin;
            peak_mag   <= run_mag;
            state      <= IDLE;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  cplx_mag2 #(
    .DATA_W (DATA_W),
    .IDX_W  (N_LOG2)
  ) u_mag (
    .clk     (clk),
    .reset   (reset),
    .data_p0 (tdata),
    .vld_p0  (accept),
    .idx_p0  (cnt),
    .mag_p2  (mag_p2),
    .vld_p2  (vld_p2),
    .idx_p2  (idx_p2)
  );

  // Strictly-greater compare keeps the lowest index on ties
  always_ff @(posedge clk) begin
    if (reset) begin
      run_mag <= '0;
      run_bin <= N_LOG2'(BIN_MIN);
    end else if (state == IDLE && start) begin
      run_mag <= '0;
      run_bin <= N_LOG2'(BIN_MIN);
    end else if (vld_p2 && in_band(idx_p2) && (mag_p2 > run_mag)) begin
      run_mag <= mag_p2;
      run_bin <= idx_p2;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) ram[cnt] <= tdata;
  end

  always_ff @(posedge clk) begin
    if (reset) rd_data <= '0;
    else       rd_data <= ram[rd_addr];
  end

endmodule

// File: tb/tb_fft_sink.sv
// Self-checking bench for fft_sink: randomized frames versus a bin-by-bin peak model.
module tb_fft_sink;

  localparam int NB   = 512;
  localparam int BMIN = 1;
  localparam int BMAX = 255;

  logic        clk, reset, start, tvalid, tlast, tready, busy, frame_done, tlast_err;
  logic [63:0] tdata, peak_mag, rd_data;
  logic [8:0]  peak_bin, rd_addr;
`ifdef FFT_SINK_STALL_EN
  logic        stall;
`endif

  fft_sink dut (
    .clk(clk), .reset(reset), .start(start), .tdata(tdata), .tvalid(tvalid), .tlast(tlast),
`ifdef FFT_SINK_STALL_EN
    .stall(stall),
`endif
    .tready(tready), .busy(busy), .frame_done(frame_done), .peak_bin(peak_bin),
    .peak_mag(peak_mag), .tlast_err(tlast_err), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  logic signed [31:0] fre [NB];
  logic signed [31:0] fim [NB];
  logic [63:0] ram_model  [NB];
  logic [63:0] prev_model [NB];

  int acc_cnt, err_first, done_lat;
  bit held, busy_ok, stall_viol;

  function automatic logic [63:0] mag2(input int k);
    longint r, i;
    r = longint'(fre[k]);
    i = longint'(fim[k]);
    return 64'(r * r) + 64'(i * i);
  endfunction

  task automatic ref_peak(output int b, output logic [63:0] m);
    b = BMIN; m = '0;
    for (int k = BMIN; k <= BMAX; k++) if (mag2(k) > m) begin m = mag2(k); b = k; end
  endtask

  task automatic set_nominal();
    for (int k = 0; k < NB; k++) begin fre[k] = 32'sd1; fim[k] = 32'sd1; end
    fre[37] = 32'sd1000; fim[37] = 32'sd0;
  endtask

  task automatic fill_random(input int lim);
    for (int k = 0; k < NB; k++) begin
      if (lim == 0) begin fre[k] = $urandom; fim[k] = $urandom; end
      else begin
        fre[k] = 32'($urandom_range(0, 2 * lim)) - 32'(lim);
        fim[k] = 32'($urandom_range(0, 2 * lim)) - 32'(lim);
      end
    end
  endtask

  // mode 0 continuous, 1 = 8 on / 4 off, 2 random gaps, 3 stall pattern
  task automatic drive_frame(input int mode, input int tlast_beat, input int start_beat,
                             input int stop_after);
    int idx, ph, k;
    bit fired, hs;
    logic [8:0]  hb;
    logic [63:0] hm;
    idx = 0; ph = 0; fired = 0; acc_cnt = 0; err_first = -1;
    held = 1; busy_ok = 1; stall_viol = 0; done_lat = -1;
    hb = peak_bin; hm = peak_mag;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (idx < stop_after && ph < 6000) begin
      case (mode)
        1:       tvalid = (ph % 12) < 8;
        2:       tvalid = ($urandom_range(0, 3) != 0);
        default: tvalid = 1'b1;
      endcase
`ifdef FFT_SINK_STALL_EN
      stall = (mode == 3) ? (((ph % 19) < 10) || ((ph % 19) >= 14)) : 1'b0;
`endif
      tdata = {fim[idx], fre[idx]};
      tlast = (idx == tlast_beat);
      if (idx == start_beat && !fired) begin start = 1'b1; fired = 1; end
      #1;
      hs = tvalid && tready;
`ifdef FFT_SINK_STALL_EN
      if (stall && tready) stall_viol = 1;
`endif
      if (!busy) busy_ok = 0;
      @(posedge clk);
      if (hs) begin ram_model[idx] = {fim[idx], fre[idx]}; idx++; acc_cnt++; end
      ph++;
      @(negedge clk);
      start = 1'b0;
      if (tlast_err === 1'b1 && err_first < 0) err_first = idx;
      if (peak_bin !== hb || peak_mag !== hm) held = 0;
    end
    tvalid = 1'b0; tlast = 1'b0;
`ifdef FFT_SINK_STALL_EN
    stall = 1'b0;
`endif
    if (stop_after == NB) begin
      k = 0;
      while (frame_done !== 1'b1 && k < 50) begin @(negedge clk); k++; end
      if (frame_done === 1'b1) done_lat = k;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    nvec++; if (tready !== 1'b0) begin nerr++; $display("FAIL reset_tready got %b want 0", tready); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b want 0", busy); end
    nvec++; if (frame_done !== 1'b0) begin nerr++; $display("FAIL reset_done got %b want 0", frame_done); end
    nvec++; if (peak_bin !== 9'd0) begin nerr++; $display("FAIL reset_peak_bin got %0d want 0", peak_bin); end
    nvec++; if (peak_mag !== 64'd0) begin nerr++; $display("FAIL reset_peak_mag got %0d want 0", peak_mag); end
    nvec++; if (tlast_err !== 1'b0) begin nerr++; $display("FAIL reset_tlast_err got %b want 0", tlast_err); end
    nvec++; if (rd_data !== 64'd0) begin nerr++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    int eb; logic [63:0] em;
    set_nominal(); ref_peak(eb, em);
    drive_frame(0, 511, -1, NB);
    nvec++; if (done_lat !== 3) begin nerr++; $display("FAIL nom_latency got %0d want 3", done_lat); end
    nvec++; if (acc_cnt !== NB) begin nerr++; $display("FAIL nom_beats got %0d want 512", acc_cnt); end
    nvec++; if (peak_bin !== 9'(eb) || peak_bin !== 9'd37) begin nerr++; $display("FAIL nom_peak_bin got %0d want %0d", peak_bin, eb); end
    nvec++; if (peak_mag !== em || peak_mag !== 64'd1000000) begin nerr++; $display("FAIL nom_peak_mag got %0d want %0d", peak_mag, em); end
    nvec++; if (tlast_err !== 1'b0) begin nerr++; $display("FAIL nom_tlast_err got %b want 0", tlast_err); end
    nvec++; if (!held) begin nerr++; $display("FAIL nom_peak_held got changed want held"); end
    nvec++; if (!busy_ok) begin nerr++; $display("FAIL nom_busy got low want high during capture"); end
    @(negedge clk);
    nvec++; if (frame_done !== 1'b0) begin nerr++; $display("FAIL nom_done_pulse got %b want 0", frame_done); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL nom_busy_after got %b want 0", busy); end
  endtask

  task automatic test_bursty();
    int eb; logic [63:0] em;
    set_nominal(); ref_peak(eb, em);
    drive_frame(1, 511, -1, NB);
    nvec++; if (done_lat !== 3) begin nerr++; $display("FAIL burst_latency got %0d want 3", done_lat); end
    nvec++; if (acc_cnt !== NB) begin nerr++; $display("FAIL burst_beats got %0d want 512", acc_cnt); end
    nvec++; if (peak_bin !== 9'(eb)) begin nerr++; $display("FAIL burst_peak_bin got %0d want %0d", peak_bin, eb); end
    nvec++; if (peak_mag !== em) begin nerr++; $display("FAIL burst_peak_mag got %0d want %0d", peak_mag, em); end
    @(negedge clk); rd_addr = 9'd37;
    @(negedge clk);
    nvec++; if (rd_data !== 64'h0000_0000_0000_03E8) begin nerr++; $display("FAIL burst_rd37 got %h want 3e8", rd_data); end
    for (int a = 0; a < NB; a++) begin
      rd_addr = 9'(a);
      @(negedge clk);
      nvec++; if (rd_data !== ram_model[a]) begin nerr++; $display("FAIL burst_readback addr %0d got %h want %h", a, rd_data, ram_model[a]); end
    end
  endtask

  task automatic run_random_check(input string tag, input int mode);
    int eb; logic [63:0] em;
    ref_peak(eb, em);
    drive_frame(mode, 511, -1, NB);
    nvec++; if (done_lat !== 3) begin nerr++; $display("FAIL %s_latency got %0d want 3", tag, done_lat); end
    nvec++; if (peak_bin !== 9'(eb)) begin nerr++; $display("FAIL %s_peak_bin got %0d want %0d", tag, peak_bin, eb); end
    nvec++; if (peak_mag !== em) begin nerr++; $display("FAIL %s_peak_mag got %0d want %0d", tag, peak_mag, em); end
  endtask

  task automatic test_band_limits();
    fill_random(1 << 20);
    fre[0] = 32'h8000_0000; fim[0] = 32'h8000_0000;
    fre[300] = 32'h7FFF_FFFF; fim[300] = 32'h7FFF_FFFF;
    run_random_check("band", 0);
    nvec++; if (peak_bin === 9'd0 || peak_bin === 9'd300) begin nerr++; $display("FAIL band_excluded got %0d want in-band bin", peak_bin); end
  endtask

  task automatic test_ties();
    fill_random(50);
    fre[20] = 32'sd3000; fim[20] = -32'sd4000;
    fre[40] = -32'sd4000; fim[40] = 32'sd3000;
    run_random_check("ties", 2);
    nvec++; if (peak_bin !== 9'd20) begin nerr++; $display("FAIL ties_lowest got %0d want 20", peak_bin); end
  endtask

  task automatic test_full_scale();
    fill_random(0);
    fre[77] = 32'h8000_0000; fim[77] = 32'h8000_0000;
    run_random_check("fullscale", 1);
    nvec++; if (peak_mag !== 64'h8000_0000_0000_0000) begin nerr++; $display("FAIL fullscale_2p63 got %h want 8000000000000000", peak_mag); end
  endtask

  task automatic test_framing_err();
    set_nominal();
    drive_frame(0, 100, -1, NB);
    nvec++; if (err_first !== 101) begin nerr++; $display("FAIL ferr_first got %0d want 101", err_first); end
    nvec++; if (acc_cnt !== NB) begin nerr++; $display("FAIL ferr_beats got %0d want 512", acc_cnt); end
    nvec++; if (done_lat !== 3) begin nerr++; $display("FAIL ferr_latency got %0d want 3", done_lat); end
    nvec++; if (tlast_err !== 1'b1) begin nerr++; $display("FAIL ferr_sticky got %b want 1", tlast_err); end
    nvec++; if (peak_bin !== 9'd37) begin nerr++; $display("FAIL ferr_peak_bin got %0d want 37", peak_bin); end
    drive_frame(0, 511, -1, NB);
    nvec++; if (err_first !== -1) begin nerr++; $display("FAIL ferr_clear_first got %0d want -1", err_first); end
    nvec++; if (tlast_err !== 1'b0) begin nerr++; $display("FAIL ferr_clean got %b want 0", tlast_err); end
  endtask

  task automatic test_start_in_recv();
    fill_random(1 << 12);
    run_random_check("startrecv", 0);
    fill_random(1 << 12);
    begin
      int eb; logic [63:0] em;
      ref_peak(eb, em);
      drive_frame(0, 511, 256, NB);
      nvec++; if (acc_cnt !== NB || done_lat !== 3) begin nerr++; $display("FAIL startrecv_ignored beats %0d lat %0d want 512/3", acc_cnt, done_lat); end
      nvec++; if (peak_bin !== 9'(eb) || peak_mag !== em) begin nerr++; $display("FAIL startrecv_peak got %0d/%0d want %0d/%0d", peak_bin, peak_mag, eb, em); end
      nvec++; if (!busy_ok) begin nerr++; $display("FAIL startrecv_busy got low want high"); end
    end
  endtask

  task automatic test_rw_collision();
    int idx, k;
    bit hs;
    logic [8:0] a;
    for (int j = 0; j < NB; j++) prev_model[j] = ram_model[j];
    fill_random(1 << 24);
    idx = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (idx < NB) begin
      tvalid = 1'b1; tdata = {fim[idx], fre[idx]}; tlast = (idx == 511);
      a = 9'(idx); rd_addr = a;
      #1; hs = tvalid && tready;
      @(posedge clk);
      if (hs) begin ram_model[idx] = {fim[idx], fre[idx]}; idx++; end
      else idx = NB;
      @(negedge clk);
      nvec++; if (rd_data !== prev_model[a]) begin nerr++; $display("FAIL rw_old_data addr %0d got %h want %h", a, rd_data, prev_model[a]); end
    end
    tvalid = 1'b0; tlast = 1'b0;
    k = 0;
    while (frame_done !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    nvec++; if (k !== 3) begin nerr++; $display("FAIL rw_latency got %0d want 3", k); end
  endtask

  task automatic test_reset_mid_frame();
    fill_random(1000);
    drive_frame(0, 511, -1, 200);
    reset = 1'b1;
    @(posedge clk); #1;
    nvec++; if (tready !== 1'b0 || busy !== 1'b0) begin nerr++; $display("FAIL midrst_ctrl got tready %b busy %b want 0 0", tready, busy); end
    nvec++; if (peak_bin !== 9'd0 || peak_mag !== 64'd0) begin nerr++; $display("FAIL midrst_peak got %0d/%0d want 0/0", peak_bin, peak_mag); end
    nvec++; if (rd_data !== 64'd0 || tlast_err !== 1'b0) begin nerr++; $display("FAIL midrst_misc got rd %h err %b want 0 0", rd_data, tlast_err); end
    @(negedge clk); reset = 1'b0;
    rd_addr = 9'd5;
    @(negedge clk);
    nvec++; if (rd_data !== ram_model[5]) begin nerr++; $display("FAIL midrst_ram5 got %h want %h", rd_data, ram_model[5]); end
    rd_addr = 9'd300;
    @(negedge clk);
    nvec++; if (rd_data !== ram_model[300]) begin nerr++; $display("FAIL midrst_ram300 got %h want %h", rd_data, ram_model[300]); end
    set_nominal();
    run_random_check("postrst", 0);
  endtask

`ifdef FFT_SINK_STALL_EN
  task automatic test_stall();
    set_nominal();
    run_random_check("stall", 3);
    nvec++; if (stall_viol) begin nerr++; $display("FAIL stall_tready got ready while stalled want not ready"); end
    nvec++; if (acc_cnt !== NB) begin nerr++; $display("FAIL stall_beats got %0d want 512", acc_cnt); end
  endtask
`endif

  initial begin
    start = 1'b0; tvalid = 1'b0; tlast = 1'b0; tdata = '0; rd_addr = '0; reset = 1'b1;
`ifdef FFT_SINK_STALL_EN
    stall = 1'b0;
`endif
    for (int j = 0; j < NB; j++) ram_model[j] = 'x;
    test_reset();
    test_nominal();
    test_bursty();
    test_band_limits();
    test_ties();
    test_full_scale();
    test_framing_err();
    test_start_in_recv();
    test_rw_collision();
    test_reset_mid_frame();
    fill_random(1 << 16);
    run_random_check("randgaps", 2);
`ifdef FFT_SINK_STALL_EN
    test_stall();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
